// File: rtl/video_timing_pkg.sv
// Shared types and reference-mode constants for the video timing receiver.
package video_timing_pkg;

   // Reference 640x480 mode geometry (pixel clock cycles / lines)
   localparam int unsigned H_TOTAL   = 800;
   localparam int unsigned H_ACTIVE  = 640;
   localparam int unsigned V_TOTAL   = 525;
   localparam int unsigned V_ACTIVE  = 480;

   // Default counter width: smallest that holds the reference line length
   localparam int unsigned DEF_CNT_W = $clog2(H_TOTAL);

   // Lock state machine
   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } vt_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous input, followed by an edge-detect
// flop. Presents either the active-normalised level or a one-cycle leading-edge
// pulse (transition into the active level), selected by LEAD.
module sync_edge_detect #(
   parameter int unsigned STAGES = 2,
   parameter bit          POL    = 1'b0,
   parameter bit          LEAD   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic out_c
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              level;

   // Synchronizer chain plus previous-value flop; reset to the active level so
   // an input already active at release never produces a false leading edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {STAGES{POL}};
         prev_q <= POL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   // Active-normalised level and leading-edge selection
   always_comb begin
      level = (sync_q[STAGES-1] == POL);
      out_c = LEAD ? (level && (prev_q != POL)) : level;
   end

endmodule

// File: rtl/video_timing_receiver.sv
// Sink-side video timing recovery: measures line/frame geometry from received
// hsync/vsync/display_on, locks onto a stable mode and regenerates pixel
// coordinates for the locked stream.
module video_timing_receiver
   import video_timing_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          HS_POL      = 1'b0,
   parameter bit          VS_POL      = 1'b0,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             de_in,
   output logic             locked,
   output logic             lock_lost,
   output logic             frame_start,
   output logic [CNT_W-1:0] h_total,
   output logic [CNT_W-1:0] h_active,
   output logic [CNT_W-1:0] v_total,
   output logic [CNT_W-1:0] v_active,
   output logic             pix_valid,
   output logic [CNT_W-1:0] x_pos,
   output logic [CNT_W-1:0] y_pos
);

   localparam int unsigned        MATCH_W    = $clog2(LOCK_FRAMES + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_FRAMES);

   logic hs_lead;
   logic vs_lead;
   logic de_lvl;

   sync_edge_detect #(.STAGES(SYNC_STAGES), .POL(HS_POL), .LEAD(1'b1)) u_hs_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (hsync_in),
      .out_c (hs_lead)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .POL(VS_POL), .LEAD(1'b1)) u_vs_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (vsync_in),
      .out_c (vs_lead)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .POL(1'b1), .LEAD(1'b0)) u_de_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (de_in),
      .out_c (de_lvl)
   );

   // Line measurement counters
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] h_de_cnt;
   // Per-frame accumulators
   logic [CNT_W-1:0] v_line_cnt;
   logic [CNT_W-1:0] v_act_cnt;
   logic [CNT_W-1:0] y_cnt;
   logic [CNT_W-1:0] frm_h_tot;
   logic [CNT_W-1:0] frm_h_act;
   logic             first_line;
   logic             frame_bad;
   // Lock FSM
   vt_state_e        state_q;
   vt_state_e        state_nxt;
   logic [MATCH_W-1:0] match_cnt;
   logic [MATCH_W-1:0] match_nxt;
   logic             meas_upd;

   // Combinational view of the line/frame being closed this cycle
   logic             h_sat;
   logic             v_sat;
   logic [CNT_W-1:0] line_len;
   logic [CNT_W-1:0] line_de;
   logic             line_act;
   logic             line_mis;
   logic             line_lock_bad;
   logic [CNT_W-1:0] frm_v_tot_c;
   logic [CNT_W-1:0] frm_v_act_c;
   logic [CNT_W-1:0] frm_h_tot_c;
   logic [CNT_W-1:0] frm_h_act_c;
   logic             frm_bad_acc_c;
   logic             frm_bad_c;
   logic             frm_eq_ref_c;

   // Line close and frame close values; a coincident hsync edge closes its line
   // into the frame that the vsync edge closes.
   always_comb begin
      h_sat         = (h_cnt == CNT_MAX);
      v_sat         = (v_line_cnt == CNT_MAX);
      line_len      = h_cnt + CNT_W'(1);
      line_de       = h_de_cnt + CNT_W'(de_lvl);
      line_act      = (h_de_cnt != '0) || de_lvl;
      line_mis      = hs_lead && !first_line && (line_len != frm_h_tot);
      line_lock_bad = hs_lead && (line_len != h_total);

      frm_v_tot_c = v_line_cnt;
      frm_v_act_c = v_act_cnt;
      frm_h_tot_c = frm_h_tot;
      frm_h_act_c = frm_h_act;
      if (hs_lead) begin
         if (!v_sat) begin
            frm_v_tot_c = v_line_cnt + CNT_W'(1);
         end
         if (line_act && (v_act_cnt != CNT_MAX)) begin
            frm_v_act_c = v_act_cnt + CNT_W'(1);
         end
         if (first_line) begin
            frm_h_tot_c = line_len;
         end
         if (line_act) begin
            frm_h_act_c = line_de;
         end
      end

      frm_bad_acc_c = frame_bad || h_sat || v_sat || line_mis;
      frm_bad_c     = frm_bad_acc_c || (frm_v_tot_c == '0);
      frm_eq_ref_c  = ({frm_h_tot_c, frm_h_act_c, frm_v_tot_c, frm_v_act_c} ==
                       {h_total, h_active, v_total, v_active});
   end

   // Line counters: both clear on the hsync leading edge; h_cnt saturates so a
   // dead hsync is visible as a stuck all-ones count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt    <= '0;
         h_de_cnt <= '0;
      end else if (hs_lead) begin
         h_cnt    <= '0;
         h_de_cnt <= '0;
      end else begin
         if (!h_sat) begin
            h_cnt <= h_cnt + CNT_W'(1);
         end
         if (de_lvl && (h_de_cnt != CNT_MAX)) begin
            h_de_cnt <= h_de_cnt + CNT_W'(1);
         end
      end
   end

   // Frame accumulators: restart on every vsync leading edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_line_cnt <= '0;
         v_act_cnt  <= '0;
         y_cnt      <= '0;
         frm_h_tot  <= '0;
         frm_h_act  <= '0;
         first_line <= 1'b1;
         frame_bad  <= 1'b0;
      end else if (vs_lead) begin
         v_line_cnt <= '0;
         v_act_cnt  <= '0;
         y_cnt      <= '0;
         frm_h_tot  <= '0;
         frm_h_act  <= '0;
         first_line <= 1'b1;
         frame_bad  <= 1'b0;
      end else begin
         v_line_cnt <= frm_v_tot_c;
         v_act_cnt  <= frm_v_act_c;
         frm_h_tot  <= frm_h_tot_c;
         frm_h_act  <= frm_h_act_c;
         frame_bad  <= frm_bad_acc_c;
         if (hs_lead) begin
            first_line <= 1'b0;
            if (line_act && (y_cnt != CNT_MAX)) begin
               y_cnt <= y_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Lock FSM next-state, match counting and measurement-update decision
   always_comb begin
      state_nxt = state_q;
      match_nxt = match_cnt;
      meas_upd  = 1'b0;
      case (state_q)
         UNLOCKED: begin
            if (vs_lead) begin
               state_nxt = ACQUIRE;
               match_nxt = '0;
            end
         end
         ACQUIRE: begin
            if (vs_lead) begin
               if (frm_bad_c) begin
                  match_nxt = '0;
               end else begin
                  meas_upd = 1'b1;
                  if (frm_eq_ref_c) begin
                     match_nxt = match_cnt + MATCH_W'(1);
                  end else begin
                     match_nxt = MATCH_W'(1);
                  end
                  if (match_nxt == MATCH_LOCK) begin
                     state_nxt = LOCKED;
                  end
               end
            end
         end
         LOCKED: begin
            if (h_sat || line_lock_bad) begin
               state_nxt = UNLOCKED;
               match_nxt = '0;
            end else if (vs_lead) begin
               meas_upd = !frm_bad_c;
               if (frm_bad_c || !frm_eq_ref_c) begin
                  state_nxt = UNLOCKED;
                  match_nxt = '0;
               end
            end
         end
         default: begin
            state_nxt = UNLOCKED;
            match_nxt = '0;
         end
      endcase
   end

   // FSM state, status pulses and measurement/reference registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= UNLOCKED;
         match_cnt   <= '0;
         locked      <= 1'b0;
         lock_lost   <= 1'b0;
         frame_start <= 1'b0;
         h_total     <= '0;
         h_active    <= '0;
         v_total     <= '0;
         v_active    <= '0;
      end else begin
         state_q     <= state_nxt;
         match_cnt   <= match_nxt;
         locked      <= (state_nxt == LOCKED);
         lock_lost   <= (state_q == LOCKED) && (state_nxt != LOCKED);
         frame_start <= vs_lead;
         if (meas_upd) begin
            h_total  <= frm_h_tot_c;
            h_active <= frm_h_act_c;
            v_total  <= frm_v_tot_c;
            v_active <= frm_v_act_c;
         end
      end
   end

   // Regenerated data-enable and coordinates, only while locked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_valid <= 1'b0;
         x_pos     <= '0;
         y_pos     <= '0;
      end else begin
         pix_valid <= de_lvl && (state_q == LOCKED);
         if (de_lvl && (state_q == LOCKED)) begin
            x_pos <= h_de_cnt;
            y_pos <= y_cnt;
         end
      end
   end

endmodule
